// File: rtl/csr_trap_unit_pkg.sv
// CSR addresses, op encodings and trap cause codes
// shared by the machine-mode CSR/trap unit.
package csr_trap_unit_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    localparam logic [1:0] CSR_OP_NONE = 2'b00;
    localparam logic [1:0] CSR_OP_RW   = 2'b01;
    localparam logic [1:0] CSR_OP_RS   = 2'b10;
    localparam logic [1:0] CSR_OP_RC   = 2'b11;

    localparam logic [2:0] EXCEP_INSTR_MISALIGNED = 3'd0;
    localparam logic [2:0] EXCEP_ILLEGAL          = 3'd1;
    localparam logic [2:0] EXCEP_BREAKPOINT       = 3'd2;
    localparam logic [2:0] EXCEP_LOAD_MISALIGNED  = 3'd3;
    localparam logic [2:0] EXCEP_STORE_MISALIGNED = 3'd4;
    localparam logic [2:0] EXCEP_ENV_CALL         = 3'd5;

    localparam logic [31:0] MCAUSE_INSTR_MISALIGNED = 32'd0;
    localparam logic [31:0] MCAUSE_ILLEGAL          = 32'd2;
    localparam logic [31:0] MCAUSE_BREAKPOINT       = 32'd3;
    localparam logic [31:0] MCAUSE_LOAD_MISALIGNED  = 32'd4;
    localparam logic [31:0] MCAUSE_STORE_MISALIGNED = 32'd6;
    localparam logic [31:0] MCAUSE_ENV_CALL         = 32'd11;

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_REDIRECT = 1'b1;

    typedef struct packed {
        logic mpie;
        logic mie;
    } mstatus_t;

    // Unknown pipeline codes are reported as illegal instruction.
    function automatic logic [31:0] excep_to_mcause(
        input logic [2:0] code
    );
        logic [31:0] v;
        case (code)
            EXCEP_INSTR_MISALIGNED: v = MCAUSE_INSTR_MISALIGNED;
            EXCEP_ILLEGAL:          v = MCAUSE_ILLEGAL;
            EXCEP_BREAKPOINT:       v = MCAUSE_BREAKPOINT;
            EXCEP_LOAD_MISALIGNED:  v = MCAUSE_LOAD_MISALIGNED;
            EXCEP_STORE_MISALIGNED: v = MCAUSE_STORE_MISALIGNED;
            EXCEP_ENV_CALL:         v = MCAUSE_ENV_CALL;
            default:                v = MCAUSE_ILLEGAL;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] csr_apply(
        input logic [1:0]  op,
        input logic [31:0] old_v,
        input logic [31:0] wdata
    );
        logic [31:0] v;
        case (op)
            CSR_OP_RW: v = wdata;
            CSR_OP_RS: v = old_v | wdata;
            CSR_OP_RC: v = old_v & ~wdata;
            default:   v = old_v;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/csr_trap_unit_if.sv
// Exception, mret, CSR access and redirect signals
// between the pipeline (master) and the CSR/trap unit (slave).
interface csr_trap_unit_if;

    logic        en_exception_i;
    logic [31:0] exception_program_counter_i;
    logic [31:0] exception_adress_i;
    logic [2:0]  exception_cause_i;
    logic        en_mret_i;
    logic        csr_en_i;
    logic [1:0]  csr_op_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i;
    logic        instr_retired_i;
    logic [31:0] csr_rdata_o;
    logic        csr_illegal_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        mstatus_mie_o;

    modport master (
        output en_exception_i,
        output exception_program_counter_i,
        output exception_adress_i,
        output exception_cause_i,
        output en_mret_i,
        output csr_en_i,
        output csr_op_i,
        output csr_addr_i,
        output csr_wdata_i,
        output instr_retired_i,
        input  csr_rdata_o,
        input  csr_illegal_o,
        input  redirect_o,
        input  redirect_pc_o,
        input  mstatus_mie_o
    );

    modport slave (
        input  en_exception_i,
        input  exception_program_counter_i,
        input  exception_adress_i,
        input  exception_cause_i,
        input  en_mret_i,
        input  csr_en_i,
        input  csr_op_i,
        input  csr_addr_i,
        input  csr_wdata_i,
        input  instr_retired_i,
        output csr_rdata_o,
        output csr_illegal_o,
        output redirect_o,
        output redirect_pc_o,
        output mstatus_mie_o
    );

endinterface

// File: rtl/csr_counter64.sv
// 64-bit counter with independent 32-bit half writes;
// used for mcycle/minstret when CSR_COUNTERS_EN is defined.
module csr_counter64 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_inc,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic [31:0] i_wdata,
    output logic [63:0] o_count
);

    logic [63:0] r_count;
    logic [63:0] w_inc;

    assign w_inc = r_count + {63'b0, i_inc};

    // A half write replaces that half; writing low also drops the carry into high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else begin
            r_count[31:0]  <= i_wr_lo ? i_wdata : w_inc[31:0];
            r_count[63:32] <= i_wr_hi ? i_wdata
                            : (i_wr_lo ? r_count[63:32] : w_inc[63:32]);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer with one-cycle fetch redirect.
// Optional CSR_COUNTERS_EN adds 64-bit mcycle/minstret and user mirrors.
module csr_trap_unit #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_1104
) (
    input logic            clk_i,
    input logic            rst_i,
    csr_trap_unit_if.slave bus
);

    import csr_trap_unit_pkg::*;

    logic [0:0]  r_state;
    mstatus_t    r_mstatus;
    logic [31:2] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:1] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;
    logic [31:0] r_redirect_pc;

    logic        w_idle;
    logic        w_take_exc;
    logic        w_take_mret;
    logic        w_impl;
    logic        w_ro;
    logic        w_wr_req;
    logic        w_csr_we;
    logic        w_mis_adr;
    logic [31:0] w_rdata;
    logic [31:0] w_wdata;
    logic [31:0] w_mstatus;
    logic        w_unused_pc0;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_take_exc  = w_idle & bus.en_exception_i;
    assign w_take_mret = w_idle & bus.en_mret_i & ~bus.en_exception_i;

    assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mstatus.mpie,
                        3'b0, r_mstatus.mie, 3'b0};

    assign w_mis_adr =
        (bus.exception_cause_i == EXCEP_LOAD_MISALIGNED) |
        (bus.exception_cause_i == EXCEP_STORE_MISALIGNED);

    assign w_unused_pc0 = bus.exception_program_counter_i[0];

`ifdef CSR_COUNTERS_EN
    logic [63:0] w_mcycle;
    logic [63:0] w_minstret;
    logic        w_cyc_lo_we;
    logic        w_cyc_hi_we;
    logic        w_ret_lo_we;
    logic        w_ret_hi_we;

    assign w_cyc_lo_we = w_csr_we & (bus.csr_addr_i == CSR_MCYCLE);
    assign w_cyc_hi_we = w_csr_we & (bus.csr_addr_i == CSR_MCYCLEH);
    assign w_ret_lo_we = w_csr_we & (bus.csr_addr_i == CSR_MINSTRET);
    assign w_ret_hi_we = w_csr_we & (bus.csr_addr_i == CSR_MINSTRETH);

    csr_counter64 u_mcycle (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_inc   (1'b1),
        .i_wr_lo (w_cyc_lo_we),
        .i_wr_hi (w_cyc_hi_we),
        .i_wdata (w_wdata),
        .o_count (w_mcycle)
    );

    csr_counter64 u_minstret (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_inc   (bus.instr_retired_i),
        .i_wr_lo (w_ret_lo_we),
        .i_wr_hi (w_ret_hi_we),
        .i_wdata (w_wdata),
        .o_count (w_minstret)
    );
`else
    logic w_unused_retired;

    assign w_unused_retired = bus.instr_retired_i;
`endif

    // Read mux plus implemented/read-only decode of the CSR address.
    always_comb begin
        w_rdata = 32'b0;
        w_impl  = 1'b1;
        w_ro    = 1'b0;
        case (bus.csr_addr_i)
            CSR_MSTATUS:  w_rdata = w_mstatus;
            CSR_MISA: begin
                w_rdata = MISA_VALUE;
                w_ro    = 1'b1;
            end
            CSR_MTVEC:    w_rdata = {r_mtvec, 2'b00};
            CSR_MSCRATCH: w_rdata = r_mscratch;
            CSR_MEPC:     w_rdata = {r_mepc, 1'b0};
            CSR_MCAUSE:   w_rdata = r_mcause;
            CSR_MTVAL:    w_rdata = r_mtval;
            CSR_MHARTID: begin
                w_rdata = HART_ID;
                w_ro    = 1'b1;
            end
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE:    w_rdata = w_mcycle[31:0];
            CSR_MCYCLEH:   w_rdata = w_mcycle[63:32];
            CSR_MINSTRET:  w_rdata = w_minstret[31:0];
            CSR_MINSTRETH: w_rdata = w_minstret[63:32];
            CSR_CYCLE: begin
                w_rdata = w_mcycle[31:0];
                w_ro    = 1'b1;
            end
            CSR_CYCLEH: begin
                w_rdata = w_mcycle[63:32];
                w_ro    = 1'b1;
            end
            CSR_INSTRET: begin
                w_rdata = w_minstret[31:0];
                w_ro    = 1'b1;
            end
            CSR_INSTRETH: begin
                w_rdata = w_minstret[63:32];
                w_ro    = 1'b1;
            end
`endif
            default:      w_impl = 1'b0;
        endcase
    end

    assign w_wr_req = (bus.csr_op_i == CSR_OP_RW) |
                      ((bus.csr_op_i != CSR_OP_NONE) &
                       (bus.csr_wdata_i != 32'b0));

    assign bus.csr_illegal_o = bus.csr_en_i &
                               (~w_impl | (w_ro & w_wr_req));

    assign w_csr_we = bus.csr_en_i & w_wr_req & ~bus.csr_illegal_o &
                      w_idle & ~bus.en_exception_i & ~bus.en_mret_i;

    assign w_wdata = csr_apply(bus.csr_op_i, w_rdata, bus.csr_wdata_i);

    // Trap entry and mret each spend one cycle in REDIRECT to pulse fetch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_redirect_pc <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take_exc) begin
                        r_state       <= ST_REDIRECT;
                        r_redirect_pc <= {r_mtvec, 2'b00};
                    end else if (w_take_mret) begin
                        r_state       <= ST_REDIRECT;
                        r_redirect_pc <= {r_mepc, 1'b0};
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Interrupt-enable stack: push on trap, pop on mret, else CSR write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mstatus <= '0;
        end else if (w_take_exc) begin
            r_mstatus.mpie <= r_mstatus.mie;
            r_mstatus.mie  <= 1'b0;
        end else if (w_take_mret) begin
            r_mstatus.mie  <= r_mstatus.mpie;
            r_mstatus.mpie <= 1'b1;
        end else if (w_csr_we && bus.csr_addr_i == CSR_MSTATUS) begin
            r_mstatus.mie  <= w_wdata[3];
            r_mstatus.mpie <= w_wdata[7];
        end
    end

    // Trap bookkeeping registers; trap entry outranks software writes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mepc   <= '0;
            r_mcause <= '0;
            r_mtval  <= '0;
        end else if (w_take_exc) begin
            r_mepc   <= bus.exception_program_counter_i[31:1];
            r_mcause <= excep_to_mcause(bus.exception_cause_i);
            r_mtval  <= w_mis_adr ? bus.exception_adress_i : 32'b0;
        end else if (w_csr_we) begin
            if (bus.csr_addr_i == CSR_MEPC)   r_mepc   <= w_wdata[31:1];
            if (bus.csr_addr_i == CSR_MCAUSE) r_mcause <= w_wdata;
            if (bus.csr_addr_i == CSR_MTVAL)  r_mtval  <= w_wdata;
        end
    end

    // Software-only registers: trap vector base and scratch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mtvec    <= RESET_MTVEC[31:2];
            r_mscratch <= '0;
        end else if (w_csr_we) begin
            if (bus.csr_addr_i == CSR_MTVEC)    r_mtvec    <= w_wdata[31:2];
            if (bus.csr_addr_i == CSR_MSCRATCH) r_mscratch <= w_wdata;
        end
    end

    assign bus.csr_rdata_o   = w_rdata;
    assign bus.redirect_o    = (r_state == ST_REDIRECT);
    assign bus.redirect_pc_o = r_redirect_pc;
    assign bus.mstatus_mie_o = r_mstatus.mie;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Bench for csr_trap_unit: CSR access, trap entry/mret,
// priorities, reset during redirect and optional counters.
module tb_csr_trap_unit;

    import csr_trap_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    logic [31:0] q_redir[$];
    logic [31:0] e_pc;
    logic        r_prev_redir = 1'b0;

    always #5 clk = ~clk;

    csr_trap_unit_if bus ();

    csr_trap_unit dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic exc, input logic [2:0] cause,
                         input logic [31:0] pc, input logic [31:0] adr,
                         input logic mret, input logic cen,
                         input logic [1:0] op, input logic [11:0] addr,
                         input logic [31:0] wd);
        @(negedge clk);
        bus.en_exception_i              = exc;
        bus.exception_cause_i           = cause;
        bus.exception_program_counter_i = pc;
        bus.exception_adress_i          = adr;
        bus.en_mret_i                   = mret;
        bus.csr_en_i                    = cen;
        bus.csr_op_i                    = op;
        bus.csr_addr_i                  = addr;
        bus.csr_wdata_i                 = wd;
        bus.instr_retired_i             = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd(input logic [11:0] addr, input logic [31:0] exp,
                      input string tag);
        drive(0, 0, 0, 0, 0, 1, CSR_OP_RS, addr, 0);
        #1;
        chk(tag, bus.csr_rdata_o, exp);
    endtask

    task automatic wr(input logic [1:0] op, input logic [11:0] addr,
                      input logic [31:0] wd, input logic exp_ill,
                      input string tag);
        drive(0, 0, 0, 0, 0, 1, op, addr, wd);
        #1;
        chk(tag, {31'b0, bus.csr_illegal_o}, {31'b0, exp_ill});
    endtask

    task automatic trap(input logic [2:0] cause, input logic [31:0] pc,
                        input logic [31:0] adr, input logic [31:0] exp_pc);
        q_redir.push_back(exp_pc);
        drive(1, cause, pc, adr, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("trap_lat", {31'b0, bus.redirect_o}, 32'd1);
    endtask

    task automatic do_mret(input logic [31:0] exp_pc);
        q_redir.push_back(exp_pc);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("mret_lat", {31'b0, bus.redirect_o}, 32'd1);
    endtask

    // Every redirect pulse must match the next expected target, one cycle wide.
    always @(posedge clk) begin
        #1;
        if (bus.redirect_o) begin
            chk("redir_single", {31'b0, r_prev_redir}, 32'd0);
            if (q_redir.size() == 0) begin
                chk("redir_unexp", {31'b0, bus.redirect_o}, 32'd0);
            end else begin
                e_pc = q_redir.pop_front();
                chk("redir_pc", bus.redirect_pc_o, e_pc);
            end
        end
        r_prev_redir = bus.redirect_o;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not end");
        $fatal(1);
    end

    initial begin
        bus.en_exception_i              = 1'b0;
        bus.exception_cause_i           = 3'd0;
        bus.exception_program_counter_i = 32'd0;
        bus.exception_adress_i          = 32'd0;
        bus.en_mret_i                   = 1'b0;
        bus.csr_en_i                    = 1'b0;
        bus.csr_op_i                    = 2'd0;
        bus.csr_addr_i                  = 12'd0;
        bus.csr_wdata_i                 = 32'd0;
        bus.instr_retired_i             = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_redir", {31'b0, bus.redirect_o}, 32'd0);
        chk("rst_redir_pc", bus.redirect_pc_o, 32'd0);
        chk("rst_mie", {31'b0, bus.mstatus_mie_o}, 32'd0);
        rd(CSR_MTVEC, 32'h0, "rst_mtvec");
        rd(CSR_MSTATUS, 32'h0000_1800, "rst_mstatus");
        rd(CSR_MEPC, 32'h0, "rst_mepc");
        rd(CSR_MSCRATCH, 32'h0, "rst_mscratch");

        wr(CSR_OP_RW, CSR_MTVEC, 32'h8000_0101, 0, "wr_mtvec_ill");
        wr(CSR_OP_RS, CSR_MSTATUS, 32'h8, 0, "set_mie_ill");
        rd(CSR_MTVEC, 32'h8000_0100, "mtvec_align");
        rd(CSR_MSTATUS, 32'h0000_1808, "mstatus_mie");
        chk("mie_out_set", {31'b0, bus.mstatus_mie_o}, 32'd1);

        trap(EXCEP_ILLEGAL, 32'h100, 32'h0, 32'h8000_0100);
        rd(CSR_MEPC, 32'h100, "ill_mepc");
        rd(CSR_MCAUSE, 32'd2, "ill_mcause");
        rd(CSR_MTVAL, 32'h0, "ill_mtval");
        rd(CSR_MSTATUS, 32'h0000_1880, "ill_mstatus");
        chk("mie_out_clr", {31'b0, bus.mstatus_mie_o}, 32'd0);

        wr(CSR_OP_RS, CSR_MSTATUS, 32'h8, 0, "set_mie2_ill");
        trap(EXCEP_LOAD_MISALIGNED, 32'h44, 32'h2003, 32'h8000_0100);
        rd(CSR_MCAUSE, 32'd4, "ldm_mcause");
        rd(CSR_MTVAL, 32'h2003, "ldm_mtval");
        rd(CSR_MEPC, 32'h44, "ldm_mepc");
        do_mret(32'h44);
        rd(CSR_MSTATUS, 32'h0000_1888, "mret_mstatus");
        chk("mret_mie", {31'b0, bus.mstatus_mie_o}, 32'd1);

        trap(EXCEP_BREAKPOINT, 32'h48, 32'h5555, 32'h8000_0100);
        rd(CSR_MCAUSE, 32'd3, "brk_mcause");
        rd(CSR_MTVAL, 32'h0, "brk_mtval");
        trap(EXCEP_STORE_MISALIGNED, 32'h4C, 32'h3001, 32'h8000_0100);
        rd(CSR_MCAUSE, 32'd6, "stm_mcause");
        rd(CSR_MTVAL, 32'h3001, "stm_mtval");

        wr(CSR_OP_RW, CSR_MSCRATCH, 32'h77, 0, "wr_scratch_ill");
        q_redir.push_back(32'h8000_0100);
        drive(1, EXCEP_ENV_CALL, 32'h200, 0, 1, 1, CSR_OP_RW, CSR_MSCRATCH, 5);
        drive(1, EXCEP_ILLEGAL, 32'h300, 0, 0, 0, 0, 0, 0);
        idle(2);
        rd(CSR_MSCRATCH, 32'h77, "prio_scratch");
        rd(CSR_MEPC, 32'h200, "prio_mepc");
        rd(CSR_MCAUSE, 32'd11, "prio_mcause");

        q_redir.push_back(32'h200);
        drive(0, 0, 0, 0, 1, 1, CSR_OP_RW, CSR_MEPC, 32'h300);
        idle(2);
        rd(CSR_MEPC, 32'h200, "mret_old_mepc");

        wr(CSR_OP_RS, CSR_MISA, 32'h0, 0, "rs_misa_ill");
        chk("rs_misa_rd", bus.csr_rdata_o, 32'h4000_1104);
        wr(CSR_OP_RW, CSR_MISA, 32'h1234, 1, "rw_misa_ill");
        rd(CSR_MISA, 32'h4000_1104, "misa_keep");
        wr(CSR_OP_RS, 12'h7C0, 32'h0, 1, "unimpl_ill");
        wr(CSR_OP_RC, CSR_MHARTID, 32'h0, 0, "rc0_hart_ill");
        rd(CSR_MHARTID, 32'h0, "hartid");
        drive(0, 0, 0, 0, 0, 0, CSR_OP_RW, 12'h7C0, 1);
        #1;
        chk("noen_ill", {31'b0, bus.csr_illegal_o}, 32'd0);

        trap(EXCEP_ILLEGAL, 32'h400, 32'h0, 32'h8000_0100);
        idle(1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rstr_redir", {31'b0, bus.redirect_o}, 32'd0);
        chk("rstr_pc", bus.redirect_pc_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rd(CSR_MTVEC, 32'h0, "rstr_mtvec");

`ifdef CSR_COUNTERS_EN
        wr(CSR_OP_RW, CSR_MCYCLE, 32'hFFFF_FFFF, 0, "wr_mcycle_ill");
        idle(2);
        rd(CSR_MCYCLE, 32'd1, "mcycle_lo");
        rd(CSR_MCYCLEH, 32'd1, "mcycle_hi");
        rd(CSR_CYCLEH, 32'd1, "cycleh_mirror");
        wr(CSR_OP_RW, CSR_MCYCLEH, 32'd5, 0, "wr_mcycleh_ill");
        rd(CSR_MCYCLEH, 32'd5, "mcycleh_wr");
        wr(CSR_OP_RW, CSR_MINSTRET, 32'd10, 0, "wr_minstret_ill");
        repeat (3) begin
            idle(1);
            bus.instr_retired_i = 1'b1;
        end
        rd(CSR_MINSTRET, 32'd13, "minstret");
        rd(CSR_INSTRETH, 32'd0, "instreth_mirror");
        wr(CSR_OP_RW, CSR_CYCLE, 32'd1, 1, "cycle_ro_ill");
`else
        wr(CSR_OP_RS, CSR_MCYCLE, 32'h0, 1, "mcycle_unimpl");
        wr(CSR_OP_RS, CSR_INSTRET, 32'h0, 1, "instret_unimpl");
`endif

        idle(2);
        chk("sb_empty", 32'(q_redir.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
